mem_copy_engine: RTL and testbench
==================================

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter: DATA_W, 16, data word width on the memory port.
REQ-002 Parameter: ADDR_W, 16, address width on the memory port.
REQ-003 Parameter: RD_LAT, 1, memory read latency in cycles (legal 1..4).
REQ-004 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port: rst  in  1  reset; synchronous, active-high.
REQ-006 Port: start  in  1  copy request, sampled in IDLE only.
REQ-007 Port: src_sel  in  2  source bank (00 weights, 01 intermediate, 10 I/O buffer).
REQ-008 Port: src_addr  in  ADDR_W  source start address.
REQ-009 Port: dst_sel  in  2  destination bank, same encoding.
REQ-010 Port: dst_addr  in  ADDR_W  destination start address.
REQ-011 Port: length  in  16  words to copy.
REQ-012 Port: abort  in  1  cancel active copy.
REQ-013 Port: busy  out  1  copy in progress.
REQ-014 Port: done  out  1  one-cycle completion pulse.
REQ-015 Port: error  out  1  one-cycle rejected-request pulse.
REQ-016 Port: words_done  out  16  words written in current/last job.
REQ-017 Port: mem_address  out  ADDR_W  to MemoryManager address.
REQ-018 Port: mem_select  out  2  to MemoryManager mem_select.
REQ-019 Port: mem_write_enable  out  1  to MemoryManager write_enable.
REQ-020 Port: mem_data_in  out  DATA_W  to MemoryManager data_in.
REQ-021 Port: mem_data_out  in  DATA_W  from MemoryManager data_out.

Function
REQ-022 States SHALL be IDLE, RD, WAIT, WR, FIN; all outputs decoded from registered state/registers only.
REQ-023 In IDLE, start=1 with both selects != 11 and length != 0 SHALL latch src/dst/length, clear words_done, go to RD next edge.
REQ-024 In IDLE, start=1 with src_sel or dst_sel = 11 SHALL pulse error for exactly one cycle next cycle, no memory access, stay IDLE.
REQ-025 In IDLE, start=1 with valid selects and length=0 SHALL go to FIN (done pulse next cycle), no memory access.
REQ-026 start while not IDLE SHALL be ignored; latched parameters SHALL not change mid-job.
REQ-027 RD (1 cycle): mem_address=src_addr+i, mem_select=src_sel, mem_write_enable=0, i = words_done.
REQ-028 WAIT (RD_LAT cycles): read address/select held; mem_data_out captured on the edge ending the last WAIT cycle.
REQ-029 WR (1 cycle): mem_address=dst_addr+i, mem_select=dst_sel, mem_data_in=captured word, mem_write_enable=1; words_done increments at the edge ending WR.
REQ-030 After WR: if words_done (incremented) = length go to FIN, else RD; per word exactly 2+RD_LAT cycles.
REQ-031 Address arithmetic SHALL be modulo 2^ADDR_W (0xFFFF+1 wraps to 0x0000).
REQ-032 FIN: done=1 for exactly one cycle, then IDLE; busy=1 in RD, WAIT, WR, FIN.
REQ-033 abort=1 sampled in RD/WAIT/WR SHALL force IDLE next edge; no done pulse; a WR cycle in which abort is sampled still completes its write and counts it.
REQ-034 abort in IDLE or FIN SHALL have no effect; start and abort together in IDLE: start wins.
REQ-035 Outside WR mem_write_enable SHALL be 0; in IDLE mem_address, mem_select, mem_data_in SHALL be 0.
REQ-036 Same-bank overlapping src/dst ranges SHALL be copied in ascending address order with no hazard detection.

Reset
REQ-037 rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, error=0, words_done=0, all mem_* outputs 0, from any state, including mid-WR.
REQ-038 rst SHALL have priority over start and abort.

Verification
REQ-039 Preload weights[0..2]=1234,5678,9ABC; start src 00/0x0000, dst 01/0x0010, length 3 -> intermediate[0x10..0x12] match, done at cycle 1+3*(2+RD_LAT), words_done=3.
REQ-040 start with dst_sel=11 -> error pulse 1 cycle, busy stays 0, mem_write_enable never asserted.
REQ-041 length=0 -> done pulse in the cycle after acceptance, no memory access.
REQ-042 src 10/0xFFFF, dst 01/0xFFFE, length 3 -> reads FFFF,0000,0001; writes FFFE,FFFF,0000.
REQ-043 length 8, abort asserted during 3rd WR -> 3 words written, words_done=3, no done, IDLE next cycle; new start then accepted.
REQ-044 rst pulsed during WAIT of word 2, RD_LAT=2 -> all outputs 0 next cycle, no further writes.

Source files
------------

// File: rtl/mem_copy_engine.sv
// Memory-to-memory copy engine in front of the MemoryManager port.
// Copies `length` words from (src_sel, src_addr) to (dst_sel, dst_addr) one at a time:
// RD (present read address), RD_LAT WAIT cycles, WR (write captured word).
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start, abort        - job request (sampled in IDLE) / cancel active job
//   src_sel/src_addr    - source bank and start address
//   dst_sel/dst_addr    - destination bank and start address
//   length              - number of words to copy
//   busy, done, error   - job active / completion pulse / rejected-request pulse
//   words_done          - words written in current or last job
//   mem_*               - MemoryManager address/select/write-enable/data port
module mem_copy_engine #(
  parameter  int unsigned DATA_W = 16,
  parameter  int unsigned ADDR_W = 16,
  parameter  int unsigned RD_LAT = 1,
  localparam int unsigned LEN_W  = 16,
  localparam int unsigned SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SEL_W-1:0]  src_sel,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [SEL_W-1:0]  dst_sel,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [LEN_W-1:0]  words_done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [SEL_W-1:0]  mem_select,
  output logic              mem_write_enable,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam int unsigned CNT_W = 3;
  localparam logic [SEL_W-1:0] SEL_BAD = 2'b11;

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, FIN} state_t;

  state_t              r_state,      w_state;
  logic [SEL_W-1:0]    r_src_sel,    w_src_sel;
  logic [SEL_W-1:0]    r_dst_sel,    w_dst_sel;
  logic [ADDR_W-1:0]   r_src_addr,   w_src_addr;
  logic [ADDR_W-1:0]   r_dst_addr,   w_dst_addr;
  logic [LEN_W-1:0]    r_len,        w_len;
  logic [LEN_W-1:0]    r_words_done, w_words_done;
  logic [CNT_W-1:0]    r_wait_cnt,   w_wait_cnt;
  logic [DATA_W-1:0]   r_data,       w_data;
  logic                r_busy,       w_busy;
  logic                r_done,       w_done;
  logic                r_error,      w_error;
  logic [ADDR_W-1:0]   r_mem_address, w_mem_address;
  logic [SEL_W-1:0]    r_mem_select,  w_mem_select;
  logic                r_mem_we,      w_mem_we;
  logic [DATA_W-1:0]   r_mem_din,     w_mem_din;

  logic w_req_bad;
  logic w_last_wait;

  assign w_req_bad   = (src_sel == SEL_BAD) || (dst_sel == SEL_BAD);
  assign w_last_wait = (r_wait_cnt == CNT_W'(RD_LAT - 1));

  // Next state, datapath and output decode; outputs are registered from the next state
  always_comb begin
    w_state      = r_state;
    w_src_sel    = r_src_sel;
    w_dst_sel    = r_dst_sel;
    w_src_addr   = r_src_addr;
    w_dst_addr   = r_dst_addr;
    w_len        = r_len;
    w_words_done = r_words_done;
    w_wait_cnt   = r_wait_cnt;
    w_data       = r_data;
    w_error      = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          if (w_req_bad) begin
            w_error = 1'b1;
          end else begin
            w_src_sel    = src_sel;
            w_dst_sel    = dst_sel;
            w_src_addr   = src_addr;
            w_dst_addr   = dst_addr;
            w_len        = length;
            w_words_done = '0;
            w_state      = (length == '0) ? FIN : RD;
          end
        end
      end
      RD: begin
        w_wait_cnt = '0;
        w_state    = abort ? IDLE : WAIT;
      end
      WAIT: begin
        if (abort) begin
          w_state = IDLE;
        end else if (w_last_wait) begin
          w_data  = mem_data_out;
          w_state = WR;
        end else begin
          w_wait_cnt = r_wait_cnt + CNT_W'(1);
        end
      end
      WR: begin
        // the write issued this cycle always lands, so it is counted even on abort
        w_words_done = r_words_done + LEN_W'(1);
        if (abort)                     w_state = IDLE;
        else if (w_words_done == r_len) w_state = FIN;
        else                           w_state = RD;
      end
      FIN:     w_state = IDLE;
      default: w_state = IDLE;
    endcase

    w_busy        = (w_state != IDLE);
    w_done        = (w_state == FIN);
    w_mem_address = '0;
    w_mem_select  = '0;
    w_mem_we      = 1'b0;
    w_mem_din     = '0;

    unique case (w_state)
      RD, WAIT: begin
        w_mem_address = w_src_addr + ADDR_W'(w_words_done);
        w_mem_select  = w_src_sel;
      end
      WR: begin
        w_mem_address = w_dst_addr + ADDR_W'(w_words_done);
        w_mem_select  = w_dst_sel;
        w_mem_we      = 1'b1;
        w_mem_din     = w_data;
      end
      default: ;
    endcase
  end

  // State and register update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_src_sel     <= '0;
      r_dst_sel     <= '0;
      r_src_addr    <= '0;
      r_dst_addr    <= '0;
      r_len         <= '0;
      r_words_done  <= '0;
      r_wait_cnt    <= '0;
      r_data        <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_mem_address <= '0;
      r_mem_select  <= '0;
      r_mem_we      <= 1'b0;
      r_mem_din     <= '0;
    end else begin
      r_state       <= w_state;
      r_src_sel     <= w_src_sel;
      r_dst_sel     <= w_dst_sel;
      r_src_addr    <= w_src_addr;
      r_dst_addr    <= w_dst_addr;
      r_len         <= w_len;
      r_words_done  <= w_words_done;
      r_wait_cnt    <= w_wait_cnt;
      r_data        <= w_data;
      r_busy        <= w_busy;
      r_done        <= w_done;
      r_error       <= w_error;
      r_mem_address <= w_mem_address;
      r_mem_select  <= w_mem_select;
      r_mem_we      <= w_mem_we;
      r_mem_din     <= w_mem_din;
    end
  end

  assign busy             = r_busy;
  assign done             = r_done;
  assign error            = r_error;
  assign words_done       = r_words_done;
  assign mem_address      = r_mem_address;
  assign mem_select       = r_mem_select;
  assign mem_write_enable = r_mem_we;
  assign mem_data_in      = r_mem_din;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: memory stub with RD_LAT read pipeline,
// job-level reference model (cycle offset within a job -> expected outputs),
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_copy_engine;

  localparam int unsigned RD_LAT = 2;
  localparam int P = 2 + RD_LAT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, abort;
  logic [1:0]  src_sel, dst_sel;
  logic [15:0] src_addr, dst_addr, length;
  logic        busy, done, error;
  logic [15:0] words_done, mem_address, mem_data_in, mem_data_out;
  logic [1:0]  mem_select;
  logic        mem_write_enable;

  mem_copy_engine #(.DATA_W(16), .ADDR_W(16), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_sel(src_sel), .src_addr(src_addr),
    .dst_sel(dst_sel), .dst_addr(dst_addr),
    .length(length), .abort(abort),
    .busy(busy), .done(done), .error(error), .words_done(words_done),
    .mem_address(mem_address), .mem_select(mem_select),
    .mem_write_enable(mem_write_enable), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  // ---------------- memory stub ----------------
  logic [15:0] smem [3][65536];
  bit          sval [3][65536];
  logic [RD_LAT*16-1:0] rd_pipe;
  bit          stub_en = 1'b0;
  logic        poke_en = 1'b0;
  logic [1:0]  poke_bank = 2'd0;
  logic [15:0] poke_addr = 16'd0, poke_val = 16'd0;

  function automatic logic [15:0] pat(input logic [1:0] b, input logic [15:0] a);
    return 16'(a * 16'd40503) ^ (16'(b) << 12) ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] stub_rd(input logic [1:0] b, input logic [15:0] a);
    if (b == 2'b11) return 16'hDEAD;
    return sval[b][a] ? smem[b][a] : pat(b, a);
  endfunction

  always @(posedge clk) begin
    if (poke_en) begin
      smem[poke_bank][poke_addr] <= poke_val;
      sval[poke_bank][poke_addr] <= 1'b1;
    end else if (stub_en && mem_write_enable && mem_select != 2'b11) begin
      smem[mem_select][mem_address] <= mem_data_in;
      sval[mem_select][mem_address] <= 1'b1;
    end
    rd_pipe <= (rd_pipe << 16) | (RD_LAT*16)'(stub_rd(mem_select, mem_address));
  end
  assign mem_data_out = rd_pipe[RD_LAT*16-1 -: 16];

  // ---------------- reference model ----------------
  logic [15:0] shm [3][65536];
  bit          shv [3][65536];

  function automatic logic [15:0] sh_rd(input logic [1:0] b, input logic [15:0] a);
    return shv[b][a] ? shm[b][a] : pat(b, a);
  endfunction

  bit          m_known = 1'b0, m_active = 1'b0, m_err = 1'b0;
  int          m_k = 0, m_len = 0, m_wd = 0;
  logic [1:0]  m_ss = 2'd0, m_ds = 2'd0;
  logic [15:0] m_sa = 16'd0, m_da = 16'd0;

  int n_tests = 0, n_fail = 0, cyc = 0;

  logic        s_busy, s_done, s_err, s_we;
  logic [15:0] s_wd, s_addr, s_din;
  logic [1:0]  s_sel;

  bit          trk = 1'b0;
  logic [15:0] rq[$], wq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s cycle %0d: got timeout expected completion", name, cyc);
  endtask

  // compare DUT outputs of the current cycle against the model
  task automatic compare();
    int w, pos;
    s_busy = busy; s_done = done; s_err = error; s_we = mem_write_enable;
    s_wd = words_done; s_addr = mem_address; s_din = mem_data_in; s_sel = mem_select;
    if (trk) begin
      if (mem_write_enable) wq.push_back(mem_address);
      else if (busy && !done && (rq.size() == 0 || rq[rq.size()-1] != mem_address))
        rq.push_back(mem_address);
    end
    if (!m_known) return;
    w = m_k / P;
    pos = m_k % P;
    chk("busy", 32'(s_busy), 32'(m_active));
    chk("done", 32'(s_done), 32'(m_active && w == m_len));
    chk("error", 32'(s_err), 32'(m_err));
    chk("words_done", 32'(s_wd), 32'(m_wd));
    if (!m_active) begin
      chk("idle_addr", 32'(s_addr), 32'd0);
      chk("idle_sel", 32'(s_sel), 32'd0);
      chk("idle_we", 32'(s_we), 32'd0);
      chk("idle_din", 32'(s_din), 32'd0);
    end else if (w == m_len) begin
      chk("fin_we", 32'(s_we), 32'd0);
    end else if (pos == P - 1) begin
      chk("wr_addr", 32'(s_addr), 32'(16'(m_da + w)));
      chk("wr_sel", 32'(s_sel), 32'(m_ds));
      chk("wr_we", 32'(s_we), 32'd1);
      chk("wr_data", 32'(s_din), 32'(sh_rd(m_ss, 16'(m_sa + w))));
    end else begin
      chk("rd_addr", 32'(s_addr), 32'(16'(m_sa + w)));
      chk("rd_sel", 32'(s_sel), 32'(m_ss));
      chk("rd_we", 32'(s_we), 32'd0);
    end
  endtask

  // advance the model across the coming edge using the inputs held for it
  task automatic advance();
    int w, pos;
    w = m_k / P;
    pos = m_k % P;
    if (m_active && w != m_len && pos == P - 1) begin
      shm[m_ds][16'(m_da + w)] = sh_rd(m_ss, 16'(m_sa + w));
      shv[m_ds][16'(m_da + w)] = 1'b1;
      m_wd = w + 1;
    end
    if (rst) begin
      m_known = 1'b1; m_active = 1'b0; m_err = 1'b0; m_wd = 0;
      return;
    end
    if (!m_known) return;
    if (!m_active) begin
      m_err = 1'b0;
      if (start) begin
        if (src_sel == 2'b11 || dst_sel == 2'b11) m_err = 1'b1;
        else begin
          m_active = 1'b1; m_k = 0; m_wd = 0; m_len = int'(length);
          m_ss = src_sel; m_ds = dst_sel; m_sa = src_addr; m_da = dst_addr;
        end
      end
    end else if (w == m_len || abort) begin
      m_active = 1'b0;
    end else begin
      m_k++;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic poke(input logic [1:0] b, input logic [15:0] a, input logic [15:0] v);
    poke_en = 1'b1; poke_bank = b; poke_addr = a; poke_val = v;
    shm[b][a] = v; shv[b][a] = 1'b1;
    cycle();
    poke_en = 1'b0;
  endtask

  task automatic start_job(input logic [1:0] ss, input logic [15:0] sa,
                           input logic [1:0] ds, input logic [15:0] da, input logic [15:0] len);
    src_sel = ss; src_addr = sa; dst_sel = ds; dst_addr = da; length = len;
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400; i++) begin
      cycle();
      if (!s_busy) return;
    end
    timeout_fail(name);
  endtask

  logic [15:0] exp_r [3];
  logic [15:0] exp_w [3];

  initial begin
    int n, wecnt;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    src_sel = 2'd0; dst_sel = 2'd0; src_addr = 16'd0; dst_addr = 16'd0; length = 16'd0;
    cycle();
    stub_en = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("reset_busy", 32'(s_busy), 32'd0);
    chk("reset_words_done", 32'(s_wd), 32'd0);
    chk("reset_mem_address", 32'(s_addr), 32'd0);

    // basic three-word copy weights -> intermediate
    poke(2'd0, 16'h0000, 16'h1234);
    poke(2'd0, 16'h0001, 16'h5678);
    poke(2'd0, 16'h0002, 16'h9ABC);
    start_job(2'd0, 16'h0000, 2'd1, 16'h0010, 16'd3);
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      cycle();
      if (s_done) begin n = i; break; end
    end
    chk("done_latency", 32'(n), 32'(1 + 3 * P));
    chk("done_words", 32'(s_wd), 32'd3);
    cycle();
    chk("copy_word0", 32'(stub_rd(2'd1, 16'h0010)), 32'h1234);
    chk("copy_word1", 32'(stub_rd(2'd1, 16'h0011)), 32'h5678);
    chk("copy_word2", 32'(stub_rd(2'd1, 16'h0012)), 32'h9ABC);

    // rejected request
    start_job(2'd0, 16'h0000, 2'd3, 16'h0005, 16'd4);
    wecnt = int'(s_we);
    cycle();
    chk("err_pulse", 32'(s_err), 32'd1);
    chk("err_busy", 32'(s_busy), 32'd0);
    wecnt += int'(s_we);
    cycle();
    chk("err_one_cycle", 32'(s_err), 32'd0);
    chk("err_busy_after", 32'(s_busy), 32'd0);
    wecnt += int'(s_we);
    chk("err_no_write", 32'(wecnt), 32'd0);

    // zero length
    start_job(2'd1, 16'h0005, 2'd2, 16'h0007, 16'd0);
    cycle();
    chk("len0_done", 32'(s_done), 32'd1);
    chk("len0_we", 32'(s_we), 32'd0);
    cycle();
    chk("len0_done_clear", 32'(s_done), 32'd0);
    chk("len0_idle", 32'(s_busy), 32'd0);

    // address wrap
    exp_r = '{16'hFFFF, 16'h0000, 16'h0001};
    exp_w = '{16'hFFFE, 16'hFFFF, 16'h0000};
    rq.delete(); wq.delete();
    trk = 1'b1;
    start_job(2'd2, 16'hFFFF, 2'd1, 16'hFFFE, 16'd3);
    wait_idle("wrap_timeout");
    trk = 1'b0;
    chk("wrap_nreads", 32'(rq.size()), 32'd3);
    chk("wrap_nwrites", 32'(wq.size()), 32'd3);
    for (int i = 0; i < 3 && i < rq.size(); i++) chk("wrap_read_addr", 32'(rq[i]), 32'(exp_r[i]));
    for (int i = 0; i < 3 && i < wq.size(); i++) chk("wrap_write_addr", 32'(wq[i]), 32'(exp_w[i]));

    // abort during the third write
    start_job(2'd0, 16'h0020, 2'd2, 16'h0040, 16'd8);
    for (int i = 1; i <= 3 * P - 1; i++) cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("abort_in_wr", 32'(s_we), 32'd1);
    cycle();
    chk("abort_idle", 32'(s_busy), 32'd0);
    chk("abort_words", 32'(s_wd), 32'd3);
    chk("abort_no_done", 32'(s_done), 32'd0);
    start_job(2'd1, 16'h0000, 2'd1, 16'h0080, 16'd1);
    cycle();
    chk("restart_accepted", 32'(s_busy), 32'd1);
    wait_idle("restart_timeout");

    // reset during WAIT of the second word
    start_job(2'd0, 16'h0300, 2'd1, 16'h0500, 16'd4);
    for (int i = 1; i <= P + 1; i++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_was_wait", 32'(s_busy && !s_we), 32'd1);
    cycle();
    chk("rst_busy", 32'(s_busy), 32'd0);
    chk("rst_done", 32'(s_done), 32'd0);
    chk("rst_error", 32'(s_err), 32'd0);
    chk("rst_words", 32'(s_wd), 32'd0);
    chk("rst_addr", 32'(s_addr), 32'd0);
    chk("rst_sel", 32'(s_sel), 32'd0);
    chk("rst_we", 32'(s_we), 32'd0);
    chk("rst_din", 32'(s_din), 32'd0);
    wecnt = 0;
    for (int i = 0; i < 10; i++) begin cycle(); wecnt += int'(s_we); end
    chk("rst_no_writes", 32'(wecnt), 32'd0);

    // overlapping same-bank copy propagates the first word upward
    start_job(2'd1, 16'h0100, 2'd1, 16'h0101, 16'd4);
    wait_idle("overlap_timeout");
    chk("overlap_fill", 32'(stub_rd(2'd1, 16'h0104)), 32'(pat(2'd1, 16'h0100)));

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom % 3 == 0);
      src_sel  = ($urandom % 16 == 0) ? 2'd3 : 2'($urandom % 3);
      dst_sel  = ($urandom % 16 == 0) ? 2'd3 : 2'($urandom % 3);
      src_addr = ($urandom % 4 == 0) ? 16'(16'hFFFC + $urandom % 8) : 16'($urandom);
      dst_addr = ($urandom % 4 == 0) ? 16'(16'hFFFC + $urandom % 8) : 16'($urandom);
      length   = ($urandom % 8 == 0) ? 16'd0 : 16'($urandom_range(1, 5));
      abort    = ($urandom % 30 == 0);
      rst      = ($urandom % 250 == 0);
      cycle();
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0;
    wait_idle("final_timeout");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
